// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the MDU op encodings, the default latencies, the counter width and the
// sequencer state encoding, plus small op-class helpers.
package mdu_pkg;

  localparam int unsigned MDU_OP_W            = 3;
  localparam int unsigned MDU_DATA_W          = 32;
  localparam int unsigned MDU_RES_W           = 2 * MDU_DATA_W;
  localparam int unsigned MDU_CNT_W           = 4;
  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  // Encodings 6 and 7 are reserved and deliberately have no name.
  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // True for the four ops that occupy the resource (MULT, MULTU, DIV, DIVU).
  function automatic logic is_muldiv(input logic [MDU_OP_W-1:0] op);
    return (op <= MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_seq_ctrl_if.sv
// E-stage <-> MDU sequencer bus.
//   master (E stage / hazard side): drives start, op, src_a, src_b, d_is_md;
//                                   observes busy, stall_req, hi, lo, done.
//   slave  (mdu_seq_ctrl):          the mirror image.
interface mdu_seq_ctrl_if;
  import mdu_pkg::*;

  logic                  start;
  logic [MDU_OP_W-1:0]   op;
  logic [MDU_DATA_W-1:0] src_a;
  logic [MDU_DATA_W-1:0] src_b;
  logic                  d_is_md;
  logic                  busy;
  logic                  stall_req;
  logic [MDU_DATA_W-1:0] hi;
  logic [MDU_DATA_W-1:0] lo;
  logic                  done;

  modport master (
    output start, op, src_a, src_b, d_is_md,
    input  busy, stall_req, hi, lo, done
  );

  modport slave (
    input  start, op, src_a, src_b, d_is_md,
    output busy, stall_req, hi, lo, done
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply/divide datapath.
//   op            : MDU op (only 0..3 are meaningful here)
//   src_a, src_b  : rs / rt operands
//   result_c      : {hi, lo} result (product, or {remainder, quotient})
//   div_by_zero_c : src_b is zero (only meaningful for DIV/DIVU)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0]   op,
  input  logic [MDU_DATA_W-1:0] src_a,
  input  logic [MDU_DATA_W-1:0] src_b,
  output logic [MDU_RES_W-1:0]  result_c,
  output logic                  div_by_zero_c
);

  logic [MDU_RES_W-1:0]  prod_s;
  logic [MDU_RES_W-1:0]  prod_u;
  logic                  signed_div;
  logic                  neg_a;
  logic                  neg_b;
  logic [MDU_DATA_W-1:0] mag_a;
  logic [MDU_DATA_W-1:0] mag_b;
  logic [MDU_DATA_W-1:0] divisor;
  logic [MDU_DATA_W-1:0] quo_u;
  logic [MDU_DATA_W-1:0] rem_u;
  logic [MDU_DATA_W-1:0] quo;
  logic [MDU_DATA_W-1:0] rem;

  // Signed divide is done on magnitudes, then the signs are reapplied:
  // quotient truncates toward zero, remainder follows the dividend.
  // The most-negative / -1 case wraps to 0x80000000 with remainder 0.
  always_comb begin
    prod_s = MDU_RES_W'($signed({{MDU_DATA_W{src_a[MDU_DATA_W-1]}}, src_a}) *
                        $signed({{MDU_DATA_W{src_b[MDU_DATA_W-1]}}, src_b}));
    prod_u = {{MDU_DATA_W{1'b0}}, src_a} * {{MDU_DATA_W{1'b0}}, src_b};

    signed_div    = (op == MDU_DIV);
    neg_a         = signed_div & src_a[MDU_DATA_W-1];
    neg_b         = signed_div & src_b[MDU_DATA_W-1];
    mag_a         = neg_a ? (~src_a + MDU_DATA_W'(1)) : src_a;
    mag_b         = neg_b ? (~src_b + MDU_DATA_W'(1)) : src_b;
    div_by_zero_c = (src_b == '0);

    // Substitute 1 for a zero divisor; the result is discarded anyway.
    divisor = div_by_zero_c ? MDU_DATA_W'(1) : mag_b;
    quo_u   = mag_a / divisor;
    rem_u   = mag_a % divisor;
    quo     = (neg_a ^ neg_b) ? (~quo_u + MDU_DATA_W'(1)) : quo_u;
    rem     = neg_a ? (~rem_u + MDU_DATA_W'(1)) : rem_u;

    result_c = {rem, quo};
    if (op == MDU_MULT) begin
      result_c = prod_s;
    end else if (op == MDU_MULTU) begin
      result_c = prod_u;
    end
  end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer for the E stage.
// Latches a mult/div result into shadow registers at the start edge, holds the
// resource busy for the configured latency, then commits HI/LO and pulses done.
// MTHI/MTLO write HI/LO directly from IDLE. stall_req freezes D while an
// MDU-dependent instruction would otherwise issue.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : slave side of mdu_seq_ctrl_if (start/op/src_a/src_b/d_is_md in,
//           busy/stall_req/hi/lo/done out)
module mdu_seq_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  mdu_seq_ctrl_if.slave bus
);

  mdu_state_e            state_q, state_d;
  logic [MDU_CNT_W-1:0]  cnt_q,   cnt_d;
  logic [MDU_DATA_W-1:0] hi_q,    hi_d;
  logic [MDU_DATA_W-1:0] lo_q,    lo_d;
  logic [MDU_RES_W-1:0]  shadow_q, shadow_d;
  logic                  dz_q,    dz_d;
  logic                  done_q,  done_d;

  logic [MDU_RES_W-1:0]  result_c;
  logic                  div_by_zero_c;
  logic                  busy;

  mdu_arith u_arith (
    .op            (bus.op),
    .src_a         (bus.src_a),
    .src_b         (bus.src_b),
    .result_c      (result_c),
    .div_by_zero_c (div_by_zero_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      shadow_q <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      shadow_q <= shadow_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    shadow_d = shadow_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_muldiv(bus.op)) begin
            shadow_d = result_c;
            dz_d     = is_div(bus.op) & div_by_zero_c;
            cnt_d    = is_div(bus.op) ? MDU_CNT_W'(DIV_CYCLES)
                                      : MDU_CNT_W'(MULT_CYCLES);
            state_d  = RUN;
          end else if (bus.op == MDU_MTHI) begin
            hi_d = bus.src_a;
          end else if (bus.op == MDU_MTLO) begin
            lo_d = bus.src_a;
          end
        end
      end
      RUN: begin
        // cnt_q == 1 marks the last busy cycle; start is ignored throughout.
        if (cnt_q == MDU_CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (!dz_q) begin
            hi_d = shadow_q[MDU_RES_W-1:MDU_DATA_W];
            lo_d = shadow_q[MDU_DATA_W-1:0];
          end
        end else begin
          cnt_d = cnt_q - MDU_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy          = (state_q == RUN);
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  // Covers the start cycle too, so D freezes before busy rises.
  assign bus.stall_req = bus.d_is_md & (busy | (bus.start & is_muldiv(bus.op)));

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed steps from the test plan
// followed by randomized ops checked against an arithmetic reference model.
module tb_mdu_seq_ctrl;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_seq_ctrl_if bus ();

  mdu_seq_ctrl #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable when this returns.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference result {hi, lo} computed with 64-bit host arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: begin
        p = sa * sb;
        return 64'(p);
      end
      3'd1: return 64'(ua * ub);
      3'd2: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.op      = 3'd0;
    bus.src_a   = 32'd0;
    bus.src_b   = 32'd0;
    bus.d_is_md = 1'b0;
  endtask

  // Issue one mult/div and check busy/done/stall/HI/LO every cycle.
  task automatic run_muldiv(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic dmd, input logic inject);
    logic [63:0] exp;
    int unsigned n;
    n   = (op >= 3'd2) ? DC : MC;
    exp = ((op >= 3'd2) && (b == 32'd0)) ? {m_hi, m_lo} : ref_result(op, a, b);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.src_a   = a;
    bus.src_b   = b;
    bus.d_is_md = dmd;
    #1;
    check("stall_start", bus.stall_req, dmd);
    check("busy_start", bus.busy, 0);
    tick();
    for (int k = 1; k <= int'(n); k++) begin
      if (inject && k == 2) begin
        bus.start = 1'b1;
        bus.op    = 3'($urandom_range(0, 5));
        bus.src_a = $urandom;
        bus.src_b = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      check("busy_run", bus.busy, 1);
      check("done_run", bus.done, 0);
      check("hi_run", bus.hi, m_hi);
      check("lo_run", bus.lo, m_lo);
      check("stall_run", bus.stall_req, dmd);
      tick();
    end
    bus.start = 1'b0;
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    check("busy_end", bus.busy, 0);
    check("done_end", bus.done, 1);
    check("hi_end", bus.hi, m_hi);
    check("lo_end", bus.lo, m_lo);
    check("stall_end", bus.stall_req, 0);
    tick();
    check("done_once", bus.done, 0);
    bus.d_is_md = 1'b0;
  endtask

  // MTHI / MTLO / reserved: one start cycle, no busy, no done.
  task automatic single_op(input logic [2:0] op, input logic [31:0] a);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.src_a   = a;
    bus.src_b   = $urandom;
    bus.d_is_md = 1'b1;
    #1;
    check("stall_single", bus.stall_req, 0);
    tick();
    bus.start = 1'b0;
    if (op == 3'd4) m_hi = a;
    if (op == 3'd5) m_lo = a;
    check("busy_single", bus.busy, 0);
    check("done_single", bus.done, 0);
    check("hi_single", bus.hi, m_hi);
    check("lo_single", bus.lo, m_lo);
    bus.d_is_md = 1'b0;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    // 1. Reset held two cycles, with a start pending (reset must win).
    idle_inputs();
    bus.start = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    bus.start = 1'b0;
    reset = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_stall", bus.stall_req, 0);
    tick();
    check("rst_busy2", bus.busy, 0);

    // 2-3. MULT, MULTU, DIV with known answers.
    run_muldiv(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    check("mult_hi_k", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo_k", bus.lo, 32'hFFFF_FFFE);
    run_muldiv(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    check("multu_hi_k", bus.hi, 32'h0000_0001);
    check("multu_lo_k", bus.lo, 32'hFFFF_FFFE);
    run_muldiv(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_hi_k", bus.hi, 32'hFFFF_FFFF);
    check("div_lo_k", bus.lo, 32'hFFFF_FFFD);

    // 4. MTHI then MTLO on consecutive cycles.
    single_op(3'd4, 32'h1234_5678);
    single_op(3'd5, 32'h9ABC_DEF0);
    check("mt_hi_k", bus.hi, 32'h1234_5678);
    check("mt_lo_k", bus.lo, 32'h9ABC_DEF0);

    // 5. DIVU by zero after MTHI, with D holding an MDU instruction.
    single_op(3'd4, 32'hAAAA_0000);
    run_muldiv(3'd3, 32'd7, 32'd0, 1'b1, 1'b0);
    check("dz_hi_k", bus.hi, 32'hAAAA_0000);
    check("dz_lo_k", bus.lo, 32'h9ABC_DEF0);

    // Reserved opcodes are ignored.
    single_op(3'd6, 32'hDEAD_BEEF);
    single_op(3'd7, 32'hCAFE_F00D);

    // 6a. Reset in the third busy cycle of a DIV discards the result.
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.src_a = 32'd100;
    bus.src_b = 32'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("abort_busy", bus.busy, 0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    check("abort_done", bus.done, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("abort_nodone", bus.done, 0);
    end

    // 6b. Second start mid-run is ignored; includes signed overflow corner.
    run_muldiv(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    run_muldiv(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check("ovf_lo_k", bus.lo, 32'h8000_0000);
    check("ovf_hi_k", bus.hi, 32'h0000_0000);
    run_muldiv(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);

    // Randomized mix.
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (rop <= 3'd3) begin
        run_muldiv(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        single_op(rop, ra);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
